// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU SPI link slice.
//   - Target index constants for the downstream command targets.
//   - Link state enumeration.
//   - sel_width(): width of a target index for a given target count.
package mcu_pkg;

  localparam int unsigned TGT_SYS = 0;
  localparam int unsigned TGT_HID = 1;
  localparam int unsigned TGT_OSD = 2;
  localparam int unsigned TGT_SDC = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Never zero, so a single-target build still has a 1-bit index.
  function automatic int unsigned sel_width(int unsigned num_targets);
    return (num_targets > 1) ? $clog2(num_targets) : 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchroniser with rise/fall pulse outputs.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high
//   d      in   asynchronous input
//   q      out  synchronised level
//   rise   out  single-clk pulse on a synchronised 0->1 transition
//   fall   out  single-clk pulse on a synchronised 1->0 transition
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      // Truncating the concatenation drops the oldest stage.
      sync_q <= SYNC_STAGES'({sync_q, d});
      prev_q <= q;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/mcu_spi_link.sv
// mcu_spi_link: SPI mode-0 slave routing MCU frames to one of NUM_TARGETS command targets.
// A frame is a target-select byte followed by payload bytes. Each payload byte is
// handed to the selected target with a one-clk strobe; the selected target's reply
// byte is shifted back to the MCU one byte behind.
// Ports:
//   clk         in   system clock, at least 8x the SCK frequency
//   reset       in   asynchronous, active-high
//   spi_ss      in   chip select, active low
//   spi_sck     in   SPI clock (CPOL=0, CPHA=0)
//   spi_mosi    in   MCU -> FPGA data, MSB first
//   spi_miso    out  FPGA -> MCU data, MSB first
//   tgt_strobe  out  one-hot single-clk pulse, tgt_data valid for that target
//   tgt_start   out  with tgt_strobe: first payload byte of the frame
//   tgt_data    out  received payload byte
//   tgt_din     in   registered reply bytes, target i at [8i+7:8i]
module mcu_spi_link
  import mcu_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_ss,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_data,
  input  logic [8*NUM_TARGETS-1:0] tgt_din
);

  localparam int unsigned SEL_W = sel_width(NUM_TARGETS);

  // Synchronisers
  logic ss_s, ss_rise, ss_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;
  logic unused_sck_level;

  // ss idles high, so reset it high to avoid a spurious frame start.
  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync_ss (
    .clk  (clk),
    .reset(reset),
    .d    (spi_ss),
    .q    (ss_s),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_sck (
    .clk  (clk),
    .reset(reset),
    .d    (spi_sck),
    .q    (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign unused_sck_level = sck_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   sel_valid_q, sel_valid_d;
  logic                   first_q, first_d;
  logic [NUM_TARGETS-1:0] strobe_q, strobe_d;
  logic                   start_q, start_d;
  logic [7:0]             data_q, data_d;

  // An sck edge coinciding with the ss rising edge still belongs to the frame,
  // so a byte completing in that cycle is delivered.
  logic       ss_low;
  logic       bit_en;
  logic       shift_en;
  logic       byte_done;
  logic [7:0] rx_byte;

  assign ss_low    = ~ss_s | ss_rise;
  assign bit_en    = sck_rise & ss_low;
  assign shift_en  = sck_fall & ss_low;
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};
  assign byte_done = bit_en & (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    first_d     = first_q;
    strobe_d    = '0;
    start_d     = 1'b0;
    data_d      = data_q;

    if (bit_en) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    if (byte_done && state_q == SELECT) begin
      sel_d       = rx_byte[SEL_W-1:0];
      sel_valid_d = 32'(rx_byte) < NUM_TARGETS;
      first_d     = 1'b1;
      state_d     = PAYLOAD;
    end

    // Bytes for an out-of-range target are dropped silently.
    if (byte_done && state_q == PAYLOAD && sel_valid_q) begin
      data_d          = rx_byte;
      strobe_d[sel_q] = 1'b1;
      start_d         = first_q;
      first_d         = 1'b0;
    end

    // Reload on the falling edge after a byte boundary: the reply reflects the
    // target's response to the previous byte.
    if (shift_en) begin
      if (bit_cnt_q == 3'd0) begin
        tx_shift_d = sel_valid_q ? tgt_din[{sel_q, 3'b000} +: 8] : 8'h00;
      end else begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end

    if (ss_fall) begin
      state_d     = SELECT;
      bit_cnt_d   = '0;
      tx_shift_d  = 8'h00;
      sel_valid_d = 1'b0;
      first_d     = 1'b0;
    end

    if (ss_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      sel_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      first_q     <= 1'b0;
      strobe_q    <= '0;
      start_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      first_q     <= first_d;
      strobe_q    <= strobe_d;
      start_q     <= start_d;
      data_q      <= data_d;
    end
  end

  assign tgt_strobe = strobe_q;
  assign tgt_start  = start_q;
  assign tgt_data   = data_q;
  assign spi_miso   = tx_shift_q[7] & ~ss_s;

endmodule

// File: tb/tb_mcu_spi_link.sv
module tb_mcu_spi_link;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_ss = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_din;

  int checks = 0;
  int passed = 0;

  mcu_spi_link #(
    .NUM_TARGETS(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_ss    (spi_ss),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .tgt_strobe(tgt_strobe),
    .tgt_start (tgt_start),
    .tgt_data  (tgt_data),
    .tgt_din   (tgt_din)
  );

  always #5 clk = ~clk;

  // Target 0 model: registers 5c after its first strobe, 42 after later ones.
  logic [7:0] rep0;
  int         rep_cnt;
  logic       rep_clr = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rep0    <= 8'h00;
      rep_cnt <= 0;
    end else if (rep_clr) begin
      rep0    <= 8'h00;
      rep_cnt <= 0;
    end else if (tgt_strobe[0]) begin
      rep0    <= (rep_cnt == 0) ? 8'h5c : 8'h42;
      rep_cnt <= rep_cnt + 1;
    end
  end

  assign tgt_din = {8'hC3, 8'hB2, 8'hA1, rep0};

  // Strobe event recorder: {strobe, start, data}
  typedef logic [12:0] ev_t;
  ev_t evq[$];
  int  orphan_start = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tgt_strobe != 4'b0000) evq.push_back({tgt_strobe, tgt_start, tgt_data});
      else if (tgt_start) orphan_start = orphan_start + 1;
    end
  end

  function automatic ev_t get_ev(input int i);
    if (i < evq.size()) return evq[i];
    return 13'h0;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit ss_with_last,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(8);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      if (ss_with_last && i == nbits - 1) spi_ss = 1'b1;
      wait_clk(8);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_ss = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end(input int gap);
    wait_clk(8);
    spi_ss = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    wait_clk(3);
    checks++; if (tgt_strobe !== 4'b0) $display("FAIL reset_strobe: got %b want 0000", tgt_strobe); else passed++;
    checks++; if (tgt_start !== 1'b0) $display("FAIL reset_start: got %b want 0", tgt_start); else passed++;
    checks++; if (tgt_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tgt_data); else passed++;
    checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else passed++;
    reset = 1'b0;
    wait_clk(8);
    checks++; if (tgt_strobe !== 4'b0) $display("FAIL idle_strobe: got %b want 0000", tgt_strobe); else passed++;
  endtask

  task automatic test_sys_frame();
    logic [7:0] r0, r1, r2, r3;
    evq.delete();
    rep_clr = 1'b1; wait_clk(1); rep_clr = 1'b0;
    frame_begin();
    xfer(8'h00, 8, 1'b0, r0);
    xfer(8'h00, 8, 1'b0, r1);
    xfer(8'h11, 8, 1'b0, r2);
    xfer(8'h22, 8, 1'b0, r3);
    frame_end(16);
    checks++; if (r0 !== 8'h00) $display("FAIL sys_miso0: got %h want 00", r0); else passed++;
    checks++; if (r1 !== 8'h00) $display("FAIL sys_miso1: got %h want 00", r1); else passed++;
    checks++; if (r2 !== 8'h5c) $display("FAIL sys_miso2: got %h want 5c", r2); else passed++;
    checks++; if (r3 !== 8'h42) $display("FAIL sys_miso3: got %h want 42", r3); else passed++;
    checks++; if (evq.size() !== 3) $display("FAIL sys_count: got %0d want 3", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b0001, 1'b1, 8'h00}) $display("FAIL sys_ev0: got %h want %h", get_ev(0), {4'b0001, 1'b1, 8'h00}); else passed++;
    checks++; if (get_ev(1) !== {4'b0001, 1'b0, 8'h11}) $display("FAIL sys_ev1: got %h want %h", get_ev(1), {4'b0001, 1'b0, 8'h11}); else passed++;
    checks++; if (get_ev(2) !== {4'b0001, 1'b0, 8'h22}) $display("FAIL sys_ev2: got %h want %h", get_ev(2), {4'b0001, 1'b0, 8'h22}); else passed++;
  endtask

  task automatic test_sdc_frame();
    logic [7:0] r0, r1, r2;
    evq.delete();
    frame_begin();
    xfer(8'h03, 8, 1'b0, r0);
    xfer(8'hAA, 8, 1'b0, r1);
    xfer(8'h55, 8, 1'b0, r2);
    frame_end(16);
    checks++; if (r0 !== 8'h00) $display("FAIL sdc_miso0: got %h want 00", r0); else passed++;
    checks++; if (r1 !== 8'hC3) $display("FAIL sdc_miso1: got %h want c3", r1); else passed++;
    checks++; if (r2 !== 8'hC3) $display("FAIL sdc_miso2: got %h want c3", r2); else passed++;
    checks++; if (evq.size() !== 2) $display("FAIL sdc_count: got %0d want 2", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b1000, 1'b1, 8'hAA}) $display("FAIL sdc_ev0: got %h want %h", get_ev(0), {4'b1000, 1'b1, 8'hAA}); else passed++;
    checks++; if (get_ev(1) !== {4'b1000, 1'b0, 8'h55}) $display("FAIL sdc_ev1: got %h want %h", get_ev(1), {4'b1000, 1'b0, 8'h55}); else passed++;
  endtask

  task automatic test_invalid_sel();
    logic [7:0] r0, r1;
    evq.delete();
    frame_begin();
    xfer(8'h07, 8, 1'b0, r0);
    xfer(8'h11, 8, 1'b0, r1);
    frame_end(16);
    checks++; if (r0 !== 8'h00) $display("FAIL inv_miso0: got %h want 00", r0); else passed++;
    checks++; if (r1 !== 8'h00) $display("FAIL inv_miso1: got %h want 00", r1); else passed++;
    checks++; if (evq.size() !== 0) $display("FAIL inv_count: got %0d want 0", evq.size()); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] r0, r1;
    evq.delete();
    frame_begin();
    xfer(8'h01, 8, 1'b0, r0);
    xfer(8'h33, 5, 1'b0, r1);
    frame_end(16);
    checks++; if (evq.size() !== 0) $display("FAIL abort_count: got %0d want 0", evq.size()); else passed++;
    // sck activity with ss high must not disturb the bit counter.
    spi_mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_sck = 1'b1; wait_clk(4);
      spi_sck = 1'b0; wait_clk(4);
    end
    frame_begin();
    xfer(8'h01, 8, 1'b0, r0);
    xfer(8'h22, 8, 1'b0, r1);
    frame_end(16);
    checks++; if (r1 !== 8'hA1) $display("FAIL abort_miso: got %h want a1", r1); else passed++;
    checks++; if (evq.size() !== 1) $display("FAIL abort_next_count: got %0d want 1", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b0010, 1'b1, 8'h22}) $display("FAIL abort_next_ev: got %h want %h", get_ev(0), {4'b0010, 1'b1, 8'h22}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    evq.delete();
    frame_begin();
    xfer(8'h02, 8, 1'b0, r);
    xfer(8'h10, 8, 1'b0, r);
    xfer(8'h20, 8, 1'b0, r);
    frame_end(4);
    frame_begin();
    xfer(8'h01, 8, 1'b0, r);
    xfer(8'h30, 8, 1'b0, r);
    frame_end(16);
    checks++; if (evq.size() !== 3) $display("FAIL b2b_count: got %0d want 3", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b0100, 1'b1, 8'h10}) $display("FAIL b2b_ev0: got %h want %h", get_ev(0), {4'b0100, 1'b1, 8'h10}); else passed++;
    checks++; if (get_ev(1) !== {4'b0100, 1'b0, 8'h20}) $display("FAIL b2b_ev1: got %h want %h", get_ev(1), {4'b0100, 1'b0, 8'h20}); else passed++;
    checks++; if (get_ev(2) !== {4'b0010, 1'b1, 8'h30}) $display("FAIL b2b_ev2: got %h want %h", get_ev(2), {4'b0010, 1'b1, 8'h30}); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] r;
    evq.delete();
    frame_begin();
    xfer(8'h00, 8, 1'b0, r);
    xfer(8'h77, 8, 1'b1, r);
    wait_clk(16);
    checks++; if (evq.size() !== 1) $display("FAIL same_count: got %0d want 1", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b0001, 1'b1, 8'h77}) $display("FAIL same_ev: got %h want %h", get_ev(0), {4'b0001, 1'b1, 8'h77}); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    evq.delete();
    frame_begin();
    xfer(8'h02, 8, 1'b0, r);
    xfer(8'h5A, 3, 1'b0, r);
    reset = 1'b1;
    #2;
    checks++; if (tgt_strobe !== 4'b0) $display("FAIL rst_mid_strobe: got %b want 0000", tgt_strobe); else passed++;
    checks++; if (tgt_start !== 1'b0) $display("FAIL rst_mid_start: got %b want 0", tgt_start); else passed++;
    checks++; if (tgt_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", tgt_data); else passed++;
    checks++; if (spi_miso !== 1'b0) $display("FAIL rst_mid_miso: got %b want 0", spi_miso); else passed++;
    spi_ss = 1'b1;
    spi_sck = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(8);
    frame_begin();
    xfer(8'h02, 8, 1'b0, r);
    xfer(8'h5A, 8, 1'b0, r);
    frame_end(16);
    checks++; if (evq.size() !== 1) $display("FAIL rst_next_count: got %0d want 1", evq.size()); else passed++;
    checks++; if (get_ev(0) !== {4'b0100, 1'b1, 8'h5A}) $display("FAIL rst_next_ev: got %h want %h", get_ev(0), {4'b0100, 1'b1, 8'h5A}); else passed++;
  endtask

  initial begin
    test_reset();
    test_sys_frame();
    test_sdc_frame();
    test_invalid_sel();
    test_abort();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    checks++; if (orphan_start !== 0) $display("FAIL start_without_strobe: got %0d want 0", orphan_start); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
